// File: rtl/watchdog_pkg.sv
// Shared types for the windowed watchdog: FSM state encoding and its width.
package watchdog_pkg;

   localparam int WDT_STATE_W = 2;

   typedef enum logic [WDT_STATE_W-1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      WARN    = 2'd2,
      EXPIRED = 2'd3
   } wdt_state_t;

endpackage

// File: rtl/wdt_counter.sv
// Watchdog up-counter: synchronous clear, increment on request, otherwise hold.
// Saturates at all-ones instead of wrapping.
module wdt_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/watchdog_timer_win.sv
// Windowed watchdog with programmable timeout, early warning and sticky expiry.
// Defining WDT_WINDOW_EN adds cfg_window/early_kick: kicks below the window expire the timer.
module watchdog_timer_win
   import watchdog_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             kick,
   input  logic [CNT_W-1:0] cfg_timeout,
   input  logic [CNT_W-1:0] cfg_warn,
   input  logic             timeout_clr,
`ifdef WDT_WINDOW_EN
   input  logic [CNT_W-1:0] cfg_window,
   output logic             early_kick,
`endif
   output logic [CNT_W-1:0] count,
   output wdt_state_t       state,
   output logic             warn,
   output logic             timeout,
   output logic             expire_pulse
);

   wdt_state_t       r_state;
   wdt_state_t       w_nextState;
   logic             w_clr;
   logic             w_inc;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W:0]   w_countInc;
   logic             w_expireHit;
   logic             w_warnHit;
   logic             w_early;
   logic             r_expirePulse;

   wdt_counter #(.CNT_W(CNT_W)) u_counter (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_inc   (w_inc),
      .o_count (w_count)
   );

   // Warning is suppressed when the threshold is at or beyond the terminal count.
   assign w_countInc  = {1'b0, w_count} + {{CNT_W{1'b0}}, 1'b1};
   assign w_expireHit = (w_count >= cfg_timeout);
   assign w_warnHit   = (w_countInc >= {1'b0, cfg_warn}) && (cfg_warn < cfg_timeout);

`ifdef WDT_WINDOW_EN
   assign w_early = kick && (cfg_window != '0) && (w_count < cfg_window);
`else
   assign w_early = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_expirePulse <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_expirePulse <= (w_nextState == EXPIRED) && (r_state != EXPIRED);
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
      case (r_state)
         IDLE: begin
            w_clr = 1'b1;
            if (enable) begin
               w_nextState = RUN;
            end
         end
         RUN, WARN: begin
            // Kick outranks a same-edge expiry unless it lands inside the window.
            if (!enable) begin
               w_nextState = IDLE;
               w_clr       = 1'b1;
            end else if (kick) begin
               if (w_early) begin
                  w_nextState = EXPIRED;
               end else begin
                  w_nextState = RUN;
                  w_clr       = 1'b1;
               end
            end else if (w_expireHit) begin
               w_nextState = EXPIRED;
            end else begin
               w_inc       = 1'b1;
               w_nextState = w_warnHit ? WARN : RUN;
            end
         end
         EXPIRED: begin
            if (timeout_clr) begin
               w_nextState = IDLE;
               w_clr       = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_clr       = 1'b1;
         end
      endcase
   end

   always_comb begin
      count        = w_count;
      state        = r_state;
      warn         = (r_state == WARN);
      timeout      = (r_state == EXPIRED);
      expire_pulse = r_expirePulse;
   end

`ifdef WDT_WINDOW_EN
   logic r_earlyKick;

   // Latched alongside the sticky expiry and released by the same clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_earlyKick <= 1'b0;
      end else if (((r_state == RUN) || (r_state == WARN)) && enable && w_early) begin
         r_earlyKick <= 1'b1;
      end else if ((r_state == EXPIRED) && timeout_clr) begin
         r_earlyKick <= 1'b0;
      end
   end

   assign early_kick = r_earlyKick;
`endif

endmodule

// File: tb/tb_watchdog_timer_win.sv
// Scoreboard bench for watchdog_timer_win (CNT_W=8): stimulus queues hand-computed
// expectations, a negedge monitor compares them. Honours WDT_WINDOW_EN.
module tb_watchdog_timer_win;
   import watchdog_pkg::*;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             kick;
   logic [CNT_W-1:0] cfgTimeout;
   logic [CNT_W-1:0] cfgWarn;
   logic             timeoutClr;
   logic [CNT_W-1:0] count;
   wdt_state_t       state;
   logic             warn;
   logic             timeout;
   logic             expirePulse;
`ifdef WDT_WINDOW_EN
   logic [CNT_W-1:0] cfgWindow;
   logic             earlyKick;
`endif

   typedef struct {
      logic [CNT_W-1:0] cnt;
      wdt_state_t       st;
      logic             w;
      logic             to;
      logic             p;
      logic             ek;
   } expT;

   expT   expQ[$];
   string nameQ[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   watchdog_timer_win #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .kick         (kick),
      .cfg_timeout  (cfgTimeout),
      .cfg_warn     (cfgWarn),
      .timeout_clr  (timeoutClr),
`ifdef WDT_WINDOW_EN
      .cfg_window   (cfgWindow),
      .early_kick   (earlyKick),
`endif
      .count        (count),
      .state        (state),
      .warn         (warn),
      .timeout      (timeout),
      .expire_pulse (expirePulse)
   );

   // Drive one cycle of inputs and let a rising edge consume them.
   task automatic applyStimulus(input logic r, input logic en, input logic k, input logic clr);
      rst        = r;
      enable     = en;
      kick       = k;
      timeoutClr = clr;
      @(posedge clk);
      #1;
   endtask

   // Queue the outputs expected after the edge just taken.
   task automatic checkOutput(input string name, input logic [CNT_W-1:0] c, input wdt_state_t s,
                              input logic p, input logic ek);
      expT e;
      e.cnt = c;
      e.st  = s;
      e.w   = (s == WARN);
      e.to  = (s == EXPIRED);
      e.p   = p;
      e.ek  = ek;
      expQ.push_back(e);
      nameQ.push_back(name);
   endtask

   expT   monE;
   string monName;
   logic  actEk;

   // Monitor: drains the scoreboard on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         while (expQ.size() > 0) begin
            monE    = expQ.pop_front();
            monName = nameQ.pop_front();
`ifdef WDT_WINDOW_EN
            actEk = earlyKick;
`else
            actEk = 1'b0;
`endif
            checks++;
            if ((count !== monE.cnt) || (state !== monE.st) || (warn !== monE.w) ||
                (timeout !== monE.to) || (expirePulse !== monE.p) || (actEk !== monE.ek)) begin
               errors++;
               $display("[TB] FAIL %s: got count=%0d state=%0d warn=%b timeout=%b pulse=%b early=%b, want count=%0d state=%0d warn=%b timeout=%b pulse=%b early=%b",
                        monName, count, state, warn, timeout, expirePulse, actEk,
                        monE.cnt, monE.st, monE.w, monE.to, monE.p, monE.ek);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeLimit: got still running, want finished");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      kick       = 1'b0;
      timeoutClr = 1'b0;
      cfgTimeout = 8'd10;
      cfgWarn    = 8'd6;
`ifdef WDT_WINDOW_EN
      cfgWindow  = 8'd0;
`endif

      applyStimulus(1, 0, 0, 0); checkOutput("reset1", 8'd0, IDLE, 0, 0);
      applyStimulus(1, 0, 0, 0); checkOutput("reset2", 8'd0, IDLE, 0, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 0); checkOutput("idleHold", 8'd0, IDLE, 0, 0);
      end

      // Basic expiry T=10 W=6
      applyStimulus(0, 1, 0, 0); checkOutput("runEntry", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("countUp", 8'(i), (i >= 6) ? WARN : RUN, 0, 0);
      end
      applyStimulus(0, 1, 0, 0); checkOutput("expire", 8'd10, EXPIRED, 1, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("pulseOnce", 8'd10, EXPIRED, 0, 0);
      applyStimulus(0, 0, 1, 0); checkOutput("stickyKick1", 8'd10, EXPIRED, 0, 0);
      applyStimulus(0, 0, 1, 0); checkOutput("stickyKick2", 8'd10, EXPIRED, 0, 0);
      applyStimulus(0, 0, 0, 1); checkOutput("clear", 8'd0, IDLE, 0, 0);

      // Periodic kick every 5 cycles
      applyStimulus(0, 1, 0, 0); checkOutput("periodicEntry", 8'd0, RUN, 0, 0);
      for (int c = 1; c <= 200; c++) begin
         applyStimulus(0, 1, (c % 5) == 0, 0);
         checkOutput("periodic", ((c % 5) == 0) ? 8'd0 : 8'(c % 5), RUN, 0, 0);
      end
      applyStimulus(0, 0, 0, 0); checkOutput("periodicStop", 8'd0, IDLE, 0, 0);

      // Kick on the same edge as count==T
      applyStimulus(0, 1, 0, 0); checkOutput("kickTEntry", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("kickTCount", 8'(i), (i >= 6) ? WARN : RUN, 0, 0);
      end
      applyStimulus(0, 1, 1, 0); checkOutput("kickAtT", 8'd0, RUN, 0, 0);
      applyStimulus(0, 0, 0, 0); checkOutput("kickTStop", 8'd0, IDLE, 0, 0);

      // T=0
      cfgTimeout = 8'd0;
      applyStimulus(0, 1, 0, 0); checkOutput("t0Entry", 8'd0, RUN, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("t0Expire", 8'd0, EXPIRED, 1, 0);
      applyStimulus(0, 0, 0, 1); checkOutput("t0Clear", 8'd0, IDLE, 0, 0);

      // W=T=20: never warns
      cfgTimeout = 8'd20;
      cfgWarn    = 8'd20;
      applyStimulus(0, 1, 0, 0); checkOutput("wEqTEntry", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("wEqTCount", 8'(i), RUN, 0, 0);
      end
      applyStimulus(0, 1, 0, 0); checkOutput("wEqTExpire", 8'd20, EXPIRED, 1, 0);
      applyStimulus(0, 0, 0, 1); checkOutput("wEqTClear", 8'd0, IDLE, 0, 0);

      // T=255: full range, no wrap
      cfgTimeout = 8'd255;
      cfgWarn    = 8'd255;
      applyStimulus(0, 1, 0, 0); checkOutput("maxEntry", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 255; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("maxCount", 8'(i), RUN, 0, 0);
      end
      applyStimulus(0, 1, 0, 0); checkOutput("maxExpire", 8'd255, EXPIRED, 1, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("maxNoWrap", 8'd255, EXPIRED, 0, 0);
      applyStimulus(0, 0, 0, 1); checkOutput("maxClear", 8'd0, IDLE, 0, 0);

      // Lower T from 50 to 3 at count 12
      cfgTimeout = 8'd50;
      cfgWarn    = 8'd100;
      applyStimulus(0, 1, 0, 0); checkOutput("lowerEntry", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("lowerCount", 8'(i), RUN, 0, 0);
      end
      cfgTimeout = 8'd3;
      applyStimulus(0, 1, 0, 0); checkOutput("lowerExpire", 8'd12, EXPIRED, 1, 0);
      applyStimulus(0, 0, 0, 1); checkOutput("lowerClear", 8'd0, IDLE, 0, 0);

      // Reset mid-count, at the expiry edge, and inside EXPIRED
      cfgTimeout = 8'd50;
      applyStimulus(0, 1, 0, 0); checkOutput("rstRunEntry", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("rstRunCount", 8'(i), RUN, 0, 0);
      end
      applyStimulus(1, 1, 0, 0); checkOutput("rstMidRun", 8'd0, IDLE, 0, 0);
      applyStimulus(0, 0, 0, 0); checkOutput("rstRunIdle", 8'd0, IDLE, 0, 0);
      cfgTimeout = 8'd2;
      applyStimulus(0, 1, 0, 0); checkOutput("rstEdgeEntry", 8'd0, RUN, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("rstEdgeCount1", 8'd1, RUN, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("rstEdgeCount2", 8'd2, RUN, 0, 0);
      applyStimulus(1, 1, 0, 0); checkOutput("rstAtExpiry", 8'd0, IDLE, 0, 0);
      cfgTimeout = 8'd0;
      applyStimulus(0, 1, 0, 0); checkOutput("rstExpEntry", 8'd0, RUN, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("rstExpExpire", 8'd0, EXPIRED, 1, 0);
      applyStimulus(1, 1, 0, 0); checkOutput("rstInExpired", 8'd0, IDLE, 0, 0);
      applyStimulus(0, 0, 0, 0); checkOutput("rstExpIdle", 8'd0, IDLE, 0, 0);

      // Early kick: window=4, T=10
      cfgTimeout = 8'd10;
      cfgWarn    = 8'd6;
`ifdef WDT_WINDOW_EN
      cfgWindow  = 8'd4;
`endif
      applyStimulus(0, 1, 0, 0); checkOutput("winEntry", 8'd0, RUN, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("winCount1", 8'd1, RUN, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("winCount2", 8'd2, RUN, 0, 0);
`ifdef WDT_WINDOW_EN
      applyStimulus(0, 1, 1, 0); checkOutput("earlyKick", 8'd2, EXPIRED, 1, 1);
      applyStimulus(0, 1, 0, 0); checkOutput("earlyHold", 8'd2, EXPIRED, 0, 1);
      applyStimulus(0, 0, 0, 1); checkOutput("earlyClear", 8'd0, IDLE, 0, 0);
      applyStimulus(0, 1, 0, 0); checkOutput("winEntry2", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("winCountB", 8'(i), RUN, 0, 0);
      end
`else
      applyStimulus(0, 1, 1, 0); checkOutput("kickAnyTime", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("winCountB", 8'(i), RUN, 0, 0);
      end
`endif
      applyStimulus(0, 1, 1, 0); checkOutput("legalKick", 8'd0, RUN, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 1, 0, 0); checkOutput("winCountC", 8'(i), RUN, 0, 0);
      end
      applyStimulus(1, 1, 0, 0); checkOutput("winRst", 8'd0, IDLE, 0, 0);
      applyStimulus(0, 0, 0, 0); checkOutput("finalIdle", 8'd0, IDLE, 0, 0);

      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
